// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD read and write controllers.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        HOLD,
        POLL_GAP,
        DONE
    } lcd_rd_state_e;

    localparam int unsigned LCD_CLK_SETUP  = 2;
    localparam int unsigned LCD_CLK_EN     = 16;
    localparam int unsigned LCD_CLK_HOLD   = 2;
    localparam int unsigned LCD_POLL_LIMIT = 255;
    localparam int unsigned LCD_BF_BIT     = 7;

    function automatic int unsigned lcd_max3(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Load-and-count phase timer: start loads a terminal count and clears the counter;
// expire is high during the cycle the counter sits at the loaded value.
module lcd_phase_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] lim_q, lim_d;
    logic         run_q, run_d;

    assign expire = run_q && (cnt_q == lim_q);

    // The counter stops at the loaded value, so it can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        run_d = run_q;
        if (start) begin
            cnt_d = '0;
            lim_d = load_val;
            run_d = 1'b1;
        end else if (expire) begin
            run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            lim_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/lcd_read_controller.sv
// HD44780-style single read cycle: drives RS/RW/EN, samples the data bus, returns the byte.
// Optional busy-flag polling is built when LCD_READ_POLL_EN is defined.
module lcd_read_controller
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_SETUP  = LCD_CLK_SETUP,
    parameter int unsigned CLK_EN     = LCD_CLK_EN,
    parameter int unsigned CLK_HOLD   = LCD_CLK_HOLD,
    parameter int unsigned POLL_LIMIT = LCD_POLL_LIMIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_start,
    input  logic       rd_rs,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_ON,
    output logic [7:0] rd_data,
    output logic       rd_busy,
    output logic       rd_done,
    output logic       rd_timeout
);

    localparam int unsigned TMAX = lcd_max3(CLK_SETUP, CLK_EN, CLK_HOLD);
    localparam int unsigned TW   = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] SETUP_LD = TW'(CLK_SETUP - 1);
    localparam logic [TW-1:0] EN_LD    = TW'(CLK_EN - 1);
    // HOLD runs CLK_HOLD+1 cycles so rd_done lands at accept+SETUP+EN+HOLD+1.
    localparam logic [TW-1:0] HOLD_LD  = TW'(CLK_HOLD);
    localparam logic [TW-1:0] GAP_LD   = TW'(CLK_HOLD - 1);

    lcd_rd_state_e state_q, state_d;
    logic          en_q, en_d;
    logic          rw_q, rw_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tmr_start;
    logic [TW-1:0] tmr_load;
    logic          tmr_expire;

`ifdef LCD_READ_POLL_EN
    localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          timeout_q, timeout_d;
`endif

    lcd_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (tmr_start),
        .load_val (tmr_load),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        rw_d      = rw_q;
        rs_d      = rs_q;
        data_d    = data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        tmr_start = 1'b0;
        tmr_load  = '0;
`ifdef LCD_READ_POLL_EN
        poll_cnt_d = poll_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (rd_start) begin
                    state_d   = SETUP;
                    rs_d      = rd_rs;
                    rw_d      = 1'b1;
                    done_d    = 1'b0;
                    tmr_start = 1'b1;
                    tmr_load  = SETUP_LD;
`ifdef LCD_READ_POLL_EN
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    state_d   = EN_HIGH;
                    en_d      = 1'b1;
                    rw_d      = 1'b1;
                    tmr_start = 1'b1;
                    tmr_load  = EN_LD;
                end
            end
            EN_HIGH: begin
                if (tmr_expire) begin
                    state_d   = HOLD;
                    en_d      = 1'b0;
                    data_d    = LCD_DATA_IN;
                    busy_d    = !rs_q && LCD_DATA_IN[LCD_BF_BIT];
                    tmr_start = 1'b1;
                    tmr_load  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tmr_expire) begin
`ifdef LCD_READ_POLL_EN
                    if (busy_q && (poll_cnt_q != PW'(POLL_LIMIT - 1))) begin
                        state_d    = POLL_GAP;
                        rw_d       = 1'b0;
                        poll_cnt_d = poll_cnt_q + PW'(1);
                        tmr_start  = 1'b1;
                        tmr_load   = GAP_LD;
                    end else begin
                        state_d   = DONE;
                        rw_d      = 1'b0;
                        done_d    = 1'b1;
                        timeout_d = busy_q;
                    end
`else
                    state_d = DONE;
                    rw_d    = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef LCD_READ_POLL_EN
            POLL_GAP: begin
                if (tmr_expire) begin
                    state_d   = SETUP;
                    rw_d      = 1'b1;
                    tmr_start = 1'b1;
                    tmr_load  = SETUP_LD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LCD_READ_POLL_EN
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef LCD_READ_POLL_EN
            poll_cnt_q <= poll_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign LCD_EN  = en_q;
    assign LCD_RW  = rw_q;
    assign LCD_RS  = rs_q;
    assign LCD_ON  = 1'b1;
    assign rd_data = data_q;
    assign rd_busy = busy_q;
    assign rd_done = done_q;
`ifdef LCD_READ_POLL_EN
    assign rd_timeout = timeout_q;
`else
    assign rd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_read_controller.sv
// Self-checking bench for lcd_read_controller; poll scenarios run when LCD_READ_POLL_EN is defined.
module tb_lcd_read_controller;

    localparam int unsigned S      = 2;
    localparam int unsigned E      = 16;
    localparam int unsigned H      = 2;
    localparam int unsigned LIM    = 4;
    localparam int unsigned LAT    = S + E + H + 1;
    localparam int unsigned BUDGET = 600;
`ifdef LCD_READ_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rd_start = 1'b0;
    logic       rd_rs = 1'b0;
    logic [7:0] LCD_DATA_IN = '0;
    logic       LCD_EN, LCD_RW, LCD_RS, LCD_ON;
    logic [7:0] rd_data;
    logic       rd_busy, rd_done, rd_timeout;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [7:0]  bus_vals[$];
    int unsigned obs_pulses, obs_en_first, obs_len_min, obs_len_max, obs_done_k, obs_rw_hi;
    logic        obs_done_seen, obs_rs_ok, obs_rw0, obs_done0, obs_tmo0;
    logic [7:0]  obs_data0;

    lcd_read_controller #(
        .CLK_SETUP  (S),
        .CLK_EN     (E),
        .CLK_HOLD   (H),
        .POLL_LIMIT (LIM)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_start    (rd_start),
        .rd_rs       (rd_rs),
        .LCD_DATA_IN (LCD_DATA_IN),
        .LCD_EN      (LCD_EN),
        .LCD_RW      (LCD_RW),
        .LCD_RS      (LCD_RS),
        .LCD_ON      (LCD_ON),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .rd_timeout  (rd_timeout)
    );

    always #5 clk = ~clk;

    // Reference: the LCD answers read i with bus_vals[i] (last value repeats).
    function automatic void model(input logic rs, output int unsigned reads,
                                  output logic [7:0] data, output logic tmo);
        int unsigned n;
        n = bus_vals.size();
        reads = 0;
        data = '0;
        tmo = 1'b0;
        for (int unsigned i = 0; i < LIM; i++) begin
            data = bus_vals[(i < n) ? i : n - 1];
            reads++;
            if (!POLL || rs || !data[7]) return;
        end
        tmo = 1'b1;
    endfunction

    // Issues one request from a negedge and observes the bus until rd_done or budget.
    task automatic run_read(input logic rs, input int unsigned ja, input int unsigned jb);
        int unsigned idx = 0;
        int unsigned cur = 0;
        logic prev_en = 1'b0;
        LCD_DATA_IN = bus_vals[0];
        rd_rs = rs;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        rd_rs = ~rs;
        obs_pulses = 0; obs_en_first = BUDGET; obs_len_min = BUDGET; obs_len_max = 0;
        obs_done_k = BUDGET; obs_rw_hi = 0; obs_done_seen = 1'b0; obs_rs_ok = 1'b1;
        obs_rw0 = LCD_RW; obs_done0 = rd_done; obs_tmo0 = rd_timeout; obs_data0 = rd_data;
        for (int unsigned k = 0; k < BUDGET; k++) begin
            if (LCD_RS !== rs) obs_rs_ok = 1'b0;
            if (LCD_EN === 1'b1) begin
                if (!prev_en) begin
                    obs_pulses++;
                    if (obs_pulses == 1) obs_en_first = k;
                    cur = 0;
                end
                cur++;
            end else if (prev_en) begin
                if (cur < obs_len_min) obs_len_min = cur;
                if (cur > obs_len_max) obs_len_max = cur;
                if (idx + 1 < bus_vals.size()) idx++;
                LCD_DATA_IN = bus_vals[idx];
            end
            if (rd_done === 1'b1) begin
                obs_done_k = k;
                obs_done_seen = 1'b1;
                break;
            end
            if (LCD_RW === 1'b1) obs_rw_hi++;
            prev_en = LCD_EN;
            rd_start = (k == ja) || (k == jb);
            @(negedge clk);
        end
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({LCD_EN, LCD_RW, LCD_RS} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {LCD_EN, LCD_RW, LCD_RS}); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", rd_data); end
        checks++; if ({rd_busy, rd_done, rd_timeout} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {rd_busy, rd_done, rd_timeout}); end
        checks++; if (LCD_ON !== 1'b1) begin failures++; $display("FAIL lcd_on got=%b exp=1", LCD_ON); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_data_read();
        bus_vals = '{8'h41};
        run_read(1'b1, BUDGET, BUDGET);
        checks++; if (obs_pulses !== 1) begin failures++; $display("FAIL data_pulses got=%0d exp=1", obs_pulses); end
        checks++; if (obs_len_min !== E || obs_len_max !== E) begin failures++; $display("FAIL data_en_len got=%0d..%0d exp=%0d", obs_len_min, obs_len_max, E); end
        checks++; if (obs_done_k !== LAT) begin failures++; $display("FAIL data_latency got=%0d exp=%0d", obs_done_k, LAT); end
        checks++; if (rd_data !== 8'h41 || rd_busy !== 1'b0) begin failures++; $display("FAIL data_value got=%0h/%b exp=41/0", rd_data, rd_busy); end
        checks++; if (obs_rw0 !== 1'b1 || obs_en_first !== S) begin failures++; $display("FAIL rw_en_offset got=rw%b en@%0d exp=rw1 en@%0d", obs_rw0, obs_en_first, S); end
        checks++; if (obs_rw_hi !== LAT || LCD_RW !== 1'b0) begin failures++; $display("FAIL rw_span got=%0d/%b exp=%0d/0", obs_rw_hi, LCD_RW, LAT); end
        checks++; if (obs_rs_ok !== 1'b1 || obs_done0 !== 1'b0) begin failures++; $display("FAIL rs_stable got=%b done0=%b exp=1/0", obs_rs_ok, obs_done0); end
    endtask

    task automatic test_busy_read();
        int unsigned reads; logic [7:0] d; logic t;
        bus_vals = '{8'h85};
        model(1'b0, reads, d, t);
        run_read(1'b0, 5, 12);
        checks++; if (obs_pulses !== reads) begin failures++; $display("FAIL busy_pulses got=%0d exp=%0d", obs_pulses, reads); end
        checks++; if (rd_data !== d || rd_busy !== 1'b1) begin failures++; $display("FAIL busy_value got=%0h/%b exp=%0h/1", rd_data, rd_busy, d); end
        checks++; if (rd_timeout !== t || obs_rs_ok !== 1'b1) begin failures++; $display("FAIL busy_tmo_rs got=%b/%b exp=%b/1", rd_timeout, obs_rs_ok, t); end
        if (reads == 1) begin
            checks++; if (obs_done_k !== LAT) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", obs_done_k, LAT); end
        end
    endtask

    task automatic test_done_edge();
        logic ok = 1'b1;
        bus_vals = '{8'h3C};
        run_read(1'b1, LAT - 1, BUDGET);
        checks++; if (obs_done_k !== LAT) begin failures++; $display("FAIL edge_latency got=%0d exp=%0d", obs_done_k, LAT); end
        for (int i = 0; i < 6; i++) begin
            if (LCD_EN !== 1'b0 || rd_done !== 1'b1 || LCD_RW !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL edge_start_ignored got=%b exp=1", ok); end
    endtask

    task automatic test_back_to_back();
        bus_vals = '{8'hC3};
        run_read(1'b1, BUDGET, BUDGET);
        checks++; if (obs_data0 !== 8'h3C || obs_done0 !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%0h/%b exp=3c/0", obs_data0, obs_done0); end
        checks++; if (rd_data !== 8'hC3 || rd_busy !== 1'b0) begin failures++; $display("FAIL b2b_value got=%0h/%b exp=c3/0", rd_data, rd_busy); end
        checks++; if (obs_done_k !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", obs_done_k, LAT); end
    endtask

    task automatic test_random();
        int unsigned reads; logic [7:0] d; logic t; logic rs;
        for (int it = 0; it < 12; it++) begin
            bus_vals.delete();
            for (int j = 0; j <= int'($urandom_range(2, 0)); j++) bus_vals.push_back(8'($urandom));
            rs = 1'($urandom);
            model(rs, reads, d, t);
            run_read(rs, $urandom_range(30, 1), BUDGET);
            checks++; if (obs_pulses !== reads || obs_done_seen !== 1'b1) begin failures++; $display("FAIL rnd%0d_pulses got=%0d done=%b exp=%0d", it, obs_pulses, obs_done_seen, reads); end
            checks++; if (rd_data !== d) begin failures++; $display("FAIL rnd%0d_data got=%0h exp=%0h", it, rd_data, d); end
            checks++; if (rd_busy !== (!rs && d[7]) || rd_timeout !== t) begin failures++; $display("FAIL rnd%0d_flags got=%b%b exp=%b%b", it, rd_busy, rd_timeout, !rs && d[7], t); end
            checks++; if (obs_len_min !== E || obs_len_max !== E || obs_rs_ok !== 1'b1) begin failures++; $display("FAIL rnd%0d_strobe got=%0d..%0d rs=%b exp=%0d", it, obs_len_min, obs_len_max, obs_rs_ok, E); end
            if (reads == 1) begin
                checks++; if (obs_done_k !== LAT) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, obs_done_k, LAT); end
            end
        end
    endtask

    task automatic test_reset_mid_en();
        LCD_DATA_IN = 8'h99;
        rd_rs = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        repeat (S + 4) @(negedge clk);
        checks++; if (LCD_EN !== 1'b1) begin failures++; $display("FAIL midrst_en_pre got=%b exp=1", LCD_EN); end
        reset_n = 1'b0;
        #1;
        checks++; if ({LCD_EN, LCD_RW, rd_done} !== 3'b000) begin failures++; $display("FAIL midrst_ctrl got=%b exp=000", {LCD_EN, LCD_RW, rd_done}); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%0h exp=0", rd_data); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef LCD_READ_POLL_EN
    task automatic test_poll_sequence();
        bus_vals = '{8'h80, 8'h80, 8'h80, 8'h07};
        run_read(1'b0, BUDGET, BUDGET);
        checks++; if (obs_pulses !== 4) begin failures++; $display("FAIL poll_pulses got=%0d exp=4", obs_pulses); end
        checks++; if (rd_data !== 8'h07 || rd_timeout !== 1'b0 || rd_busy !== 1'b0) begin failures++; $display("FAIL poll_result got=%0h/%b/%b exp=07/0/0", rd_data, rd_timeout, rd_busy); end
    endtask

    task automatic test_poll_timeout();
        bus_vals = '{8'hFF};
        run_read(1'b0, BUDGET, BUDGET);
        checks++; if (obs_pulses !== LIM || obs_done_seen !== 1'b1) begin failures++; $display("FAIL tmo_pulses got=%0d done=%b exp=%0d", obs_pulses, obs_done_seen, LIM); end
        checks++; if (rd_timeout !== 1'b1 || rd_busy !== 1'b1 || rd_data !== 8'hFF) begin failures++; $display("FAIL tmo_flags got=%b/%b/%0h exp=1/1/ff", rd_timeout, rd_busy, rd_data); end
        bus_vals = '{8'h12};
        run_read(1'b1, BUDGET, BUDGET);
        checks++; if (obs_tmo0 !== 1'b0 || rd_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b/%b exp=0/0", obs_tmo0, rd_timeout); end
    endtask
`else
    task automatic test_no_poll();
        bus_vals = '{8'h80, 8'h07};
        run_read(1'b0, BUDGET, BUDGET);
        checks++; if (obs_pulses !== 1 || obs_done_k !== LAT) begin failures++; $display("FAIL nopoll_pulses got=%0d@%0d exp=1@%0d", obs_pulses, obs_done_k, LAT); end
        checks++; if (rd_data !== 8'h80 || rd_busy !== 1'b1 || rd_timeout !== 1'b0) begin failures++; $display("FAIL nopoll_result got=%0h/%b/%b exp=80/1/0", rd_data, rd_busy, rd_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_read();
        test_busy_read();
        test_done_edge();
        test_back_to_back();
        test_random();
        test_reset_mid_en();
`ifdef LCD_READ_POLL_EN
        test_poll_sequence();
        test_poll_timeout();
`else
        test_no_poll();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
